axi_round_arb: RTL and testbench
================================

// Module: axi_round_arb
// PURPOSE
//  Shares one rounding datapath (WIDTH_IN -> WIDTH_OUT) between NUM_PORTS AXI-stream requesters.
//  Packet-level round-robin: grant switches only after tlast; output tagged with source port in o_tuser.
//  Per-port rounding mode set over the settings bus and latched at packet start.
//  Sits between per-channel DSP stages and a shared narrow output stream.
// PARAMETERS
//  NUM_PORTS   4   number of input streams (>=2)
//  WIDTH_IN    17  input sample width
//  WIDTH_OUT   16  output sample width; WIDTH_IN > WIDTH_OUT required
//  SR_BASE     0   settings address of port 0 mode register; port p at SR_BASE+p
//  RESET_MODE  2   mode loaded into every port register at reset
// PORTS
//  clk       in   1                     clock
//  reset     in   1                     synchronous, active-high
//  set_stb   in   1                     settings write strobe
//  set_addr  in   8                     settings address
//  set_data  in   32                    settings data; [1:0] = mode
//  i_tdata   in   NUM_PORTS*WIDTH_IN    port p at [p*WIDTH_IN +: WIDTH_IN]
//  i_tlast   in   NUM_PORTS             per-port tlast
//  i_tvalid  in   NUM_PORTS             per-port tvalid
//  i_tready  out  NUM_PORTS             per-port tready
//  o_tdata   out  WIDTH_OUT             rounded sample
//  o_tlast   out  1                     end of packet
//  o_tvalid  out  1                     output valid
//  o_tready  in   1                     output ready
//  o_tuser   out  $clog2(NUM_PORTS)     source port of current beat
//  busy      out  1                     high while a packet is granted
// BEHAVIOUR
//  Reset: state IDLE, i_tready=0, o_tvalid=0, o_tlast=0, o_tdata=0, o_tuser=0, busy=0,
//   last_grant=NUM_PORTS-1, all mode regs=RESET_MODE. Reset mid-packet drops buffered beat and remainder.
//  Modes: 0 trunc (corr=0); 1 round-to-zero (corr=sign & |discarded bits);
//   2 and 3 round-to-nearest-safe (corr=MSB discarded bit, forced 0 when sign=0 and
//   in[WIDTH_IN-2:WIDTH_IN-WIDTH_OUT] all ones). out = in[WIDTH_IN-1 -: WIDTH_OUT] + corr, mod 2^WIDTH_OUT.
//  Settings: write when set_stb and set_addr in SR_BASE..SR_BASE+NUM_PORTS-1; other addresses ignored.
//  FSM IDLE: search i_tvalid starting at last_grant+1 with wrap; on hit, grant<=p, active_mode<=mode[p],
//   last_grant<=p, -> BUSY (one-cycle bubble per packet). No request: stay IDLE.
//  FSM BUSY: i_tready[grant] = !o_tvalid | o_tready; all other i_tready=0. On i_tvalid&i_tready with
//   i_tlast -> IDLE. busy=1 only in BUSY.
//  Mode write to the granted port during BUSY affects the next packet only.
//  Output: single register stage, latency 1 cycle from input handshake to o_tvalid. Load on accept;
//   o_tvalid clears when o_tready & no new accept. o_tdata/o_tlast/o_tuser stable while o_tvalid&!o_tready.
//  Full throughput (1 beat/cycle) within a packet under continuous o_tready.
//  Zero-length packets impossible; single-beat packet (tlast on first beat) returns to IDLE next cycle.
// STRUCTURE
//  Package axi_round_pkg: mode encodings (RND_TRUNC=0, RND_RTZ=1, RND_NEAREST=2), FSM state typedef.
//  Sub-module round_corr_calc: combinational WIDTH_IN->WIDTH_OUT rounding given mode; reused elsewhere.
//  Top holds settings regs, round-robin pointer, FSM, output register.
// TESTING (WIDTH_IN=17, WIDTH_OUT=16, NUM_PORTS=4)
//  Mode 2, port0 beat 17'h00003 -> o_tdata 16'h0002; 17'h0FFFF -> 16'h7FFF (no wrap to 8000).
//  Port0 mode 1 beat 17'h1FFFF -> 16'h0000; then mode 0, same beat next packet -> 16'hFFFF.
//  After reset ports 0 and 2 each hold 3-beat packets -> o_tuser 0,0,0,2,2,2; o_tlast on beats 3 and 6.
//  Ports 1,3 continuously valid -> grants alternate 1,3,1,3; never switch mid-packet.
//  o_tready held low 5 cycles mid-packet -> o_tdata stable, i_tready low, no beat lost or duplicated.
//  Mode write to granted port mid-packet -> current packet old mode; reset mid-packet -> all outputs reset next cycle.

Source files
------------

// File: rtl/axi_round_pkg.sv
// Shared definitions for the round-robin rounding arbiter: rounding mode
// encodings and the arbiter FSM state type.
package axi_round_pkg;

  localparam logic [1:0] RND_TRUNC   = 2'd0;
  localparam logic [1:0] RND_RTZ     = 2'd1;
  localparam logic [1:0] RND_NEAREST = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/round_corr_calc.sv
// Combinational WIDTH_IN -> WIDTH_OUT rounding. Keeps the top WIDTH_OUT bits
// and adds a one-LSB correction chosen by the rounding mode. Nearest mode
// suppresses the correction for the largest positive kept value so that it
// cannot wrap to the most negative code.
module round_corr_calc
  import axi_round_pkg::*;
#(
  parameter int WIDTH_IN  = 17,
  parameter int WIDTH_OUT = 16
) (
  input  logic [1:0]           mode,
  input  logic [WIDTH_IN-1:0]  in_data,
  output logic [WIDTH_OUT-1:0] out_data
);

  localparam int DROP = WIDTH_IN - WIDTH_OUT;

  logic                 sign_bit;
  logic [DROP-1:0]      drop_bits;
  logic [WIDTH_OUT-1:0] kept_bits;
  logic                 pos_max;
  logic                 corr;

  assign sign_bit  = in_data[WIDTH_IN-1];
  assign drop_bits = in_data[DROP-1:0];
  assign kept_bits = in_data[WIDTH_IN-1 -: WIDTH_OUT];
  assign pos_max   = !sign_bit && (&in_data[WIDTH_IN-2:DROP]);

  // Pick the correction bit for the current mode; mode 3 behaves like nearest.
  always_comb begin
    corr = 1'b0;
    case (mode)
      RND_TRUNC: corr = 1'b0;
      RND_RTZ:   corr = sign_bit && (|drop_bits);
      default:   corr = drop_bits[DROP-1] && !pos_max;
    endcase
  end

  assign out_data = kept_bits + WIDTH_OUT'(corr);

endmodule

// File: rtl/axi_round_arb.sv
// Packet-level round-robin arbiter sharing one rounding datapath between
// NUM_PORTS AXI-stream inputs. Each port has its own rounding mode register,
// sampled when its packet is granted. Output is a single register stage
// tagged with the source port in o_tuser.
module axi_round_arb
  import axi_round_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int WIDTH_IN   = 17,
  parameter int WIDTH_OUT  = 16,
  parameter int SR_BASE    = 0,
  parameter int RESET_MODE = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            set_stb,
  input  logic [7:0]                      set_addr,
  input  logic [31:0]                     set_data,
  input  logic [NUM_PORTS*WIDTH_IN-1:0]   i_tdata,
  input  logic [NUM_PORTS-1:0]            i_tlast,
  input  logic [NUM_PORTS-1:0]            i_tvalid,
  output logic [NUM_PORTS-1:0]            i_tready,
  output logic [WIDTH_OUT-1:0]            o_tdata,
  output logic                            o_tlast,
  output logic                            o_tvalid,
  input  logic                            o_tready,
  output logic [$clog2(NUM_PORTS)-1:0]    o_tuser,
  output logic                            busy
);

  localparam int PW = $clog2(NUM_PORTS);

  arb_state_t           state_reg, state_next;
  logic [PW-1:0]        grant_reg, grant_next;
  logic [PW-1:0]        last_grant_reg, last_grant_next;
  logic [1:0]           active_mode_reg, active_mode_next;
  logic [1:0]           mode_reg [NUM_PORTS];

  logic [WIDTH_IN-1:0]  sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 out_free;
  logic                 accept;
  logic [WIDTH_OUT-1:0] rounded;

  logic [WIDTH_OUT-1:0] o_tdata_reg;
  logic                 o_tlast_reg;
  logic                 o_tvalid_reg;
  logic [PW-1:0]        o_tuser_reg;

  int                   cand;
  logic                 found;
  logic                 set_data_unused;

  assign set_data_unused = ^set_data[31:2];

  // Per-port mode registers written over the settings bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) mode_reg[p] <= 2'(RESET_MODE);
    end else if (set_stb) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (int'(set_addr) == SR_BASE + p) mode_reg[p] <= set_data[1:0];
      end
    end
  end

  assign sel_data  = i_tdata[int'(grant_reg)*WIDTH_IN +: WIDTH_IN];
  assign sel_valid = i_tvalid[grant_reg];
  assign sel_last  = i_tlast[grant_reg];
  assign out_free  = !o_tvalid_reg || o_tready;
  assign accept    = (state_reg == ST_BUSY) && sel_valid && out_free;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
      assign i_tready[gi] = (state_reg == ST_BUSY) && (grant_reg == PW'(gi)) && out_free;
    end
  endgenerate

  round_corr_calc #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT)
  ) u_round (
    .mode     (active_mode_reg),
    .in_data  (sel_data),
    .out_data (rounded)
  );

  // Next-state: round-robin search from last_grant+1 in IDLE, hold grant until tlast.
  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_grant_next  = last_grant_reg;
    active_mode_next = active_mode_reg;
    found            = 1'b0;
    cand             = 0;
    case (state_reg)
      ST_IDLE: begin
        for (int i = 1; i <= NUM_PORTS; i++) begin
          cand = int'(last_grant_reg) + i;
          if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
          if (!found && i_tvalid[cand]) begin
            found            = 1'b1;
            grant_next       = PW'(cand);
            last_grant_next  = PW'(cand);
            active_mode_next = mode_reg[cand];
          end
        end
        if (found) state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (accept && sel_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= '0;
      last_grant_reg  <= PW'(NUM_PORTS - 1);
      active_mode_reg <= 2'(RESET_MODE);
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      last_grant_reg  <= last_grant_next;
      active_mode_reg <= active_mode_next;
    end
  end

  // Output register: load on accept, drop valid once the sink takes the beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_tdata_reg  <= '0;
      o_tlast_reg  <= 1'b0;
      o_tvalid_reg <= 1'b0;
      o_tuser_reg  <= '0;
    end else if (accept) begin
      o_tdata_reg  <= rounded;
      o_tlast_reg  <= sel_last;
      o_tvalid_reg <= 1'b1;
      o_tuser_reg  <= grant_reg;
    end else if (o_tready) begin
      o_tvalid_reg <= 1'b0;
    end
  end

  assign o_tdata  = o_tdata_reg;
  assign o_tlast  = o_tlast_reg;
  assign o_tvalid = o_tvalid_reg;
  assign o_tuser  = o_tuser_reg;
  assign busy     = (state_reg == ST_BUSY);

endmodule

// File: tb/tb_axi_round_arb.sv
// Directed bench for axi_round_arb with NUM_PORTS=4, 17->16 bits.
// Per-port source queues feed the inputs; a monitor logs output beats as
// {tuser, tlast, tdata} for comparison against hand-computed values.
module tb_axi_round_arb;

  localparam int NP = 4;
  localparam int WI = 17;
  localparam int WO = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              set_stb = 1'b0;
  logic [7:0]        set_addr = '0;
  logic [31:0]       set_data = '0;
  logic [NP*WI-1:0]  i_tdata = '0;
  logic [NP-1:0]     i_tlast = '0;
  logic [NP-1:0]     i_tvalid = '0;
  logic [NP-1:0]     i_tready;
  logic [WO-1:0]     o_tdata;
  logic              o_tlast;
  logic              o_tvalid;
  logic              o_tready = 1'b0;
  logic [1:0]        o_tuser;
  logic              busy;

  int tests = 0;
  int fails = 0;

  logic [WI:0]   src_q [NP][$];
  logic [31:0]   out_q [$];
  logic [NP-1:0] hs_in = '0;
  logic [WI:0]   head;
  logic [WO-1:0] held;

  always #5 clk = ~clk;

  axi_round_arb #(
    .NUM_PORTS(NP), .WIDTH_IN(WI), .WIDTH_OUT(WO), .SR_BASE(0), .RESET_MODE(2)
  ) dut (
    .clk(clk), .reset(reset),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_tuser(o_tuser), .busy(busy)
  );

  // Sample handshakes mid-cycle; they complete on the following rising edge.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) hs_in[p] = i_tvalid[p] && i_tready[p] && !reset;
    if (o_tvalid && o_tready && !reset) out_q.push_back({13'b0, o_tuser, o_tlast, o_tdata});
  end

  // Source model: pop accepted beats and present the next queue head.
  always @(posedge clk) begin
    #2;
    for (int p = 0; p < NP; p++) begin
      if (hs_in[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      if (src_q[p].size() > 0) begin
        head = src_q[p][0];
        i_tvalid[p] = 1'b1;
        i_tlast[p] = head[WI];
        i_tdata[p*WI +: WI] = head[WI-1:0];
      end else begin
        i_tvalid[p] = 1'b0;
        i_tlast[p] = 1'b0;
        i_tdata[p*WI +: WI] = '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input logic last, input logic [WI-1:0] d);
    src_q[p].push_back({last, d});
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    tick();
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_out(input int n, input string tag);
    int cyc = 0;
    while (out_q.size() < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 32'(out_q.size() >= n), 32'd1);
  endtask

  task automatic chk_seq(input string tag, input logic [31:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < out_q.size()) chk($sformatf("%s[%0d]", tag, i), out_q[i], exp[i]);
      else chk($sformatf("%s[%0d]_missing", tag, i), 32'hDEAD_BEEF, exp[i]);
    end
    out_q.delete();
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_tready", 32'(i_tready), 32'h0);
    chk("rst_o_tvalid", 32'(o_tvalid), 32'h0);
    chk("rst_o_tlast",  32'(o_tlast),  32'h0);
    chk("rst_o_tdata",  32'(o_tdata),  32'h0);
    chk("rst_o_tuser",  32'(o_tuser),  32'h0);
    chk("rst_busy",     32'(busy),     32'h0);
    tick();
    reset = 1'b0;
    o_tready = 1'b1;

    // Unmapped address must not change port 0 (stays nearest)
    wr(8'h04, 32'h0);
    push(0, 1'b0, 17'h00003);
    push(0, 1'b1, 17'h0FFFF);
    @(negedge clk);
    chk("p0_idle_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("p0_grant_busy", 32'(busy), 32'h1);
    chk("p0_grant_ready", 32'(i_tready), 32'h1);
    @(negedge clk);
    chk("p0_b0_valid", 32'(o_tvalid), 32'h1);
    chk("p0_b0_data", 32'(o_tdata), 32'h0002);
    chk("p0_b0_last", 32'(o_tlast), 32'h0);
    @(negedge clk);
    chk("p0_b1_data", 32'(o_tdata), 32'h7FFF);
    chk("p0_b1_last", 32'(o_tlast), 32'h1);
    chk("p0_b1_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("p0_drain_valid", 32'(o_tvalid), 32'h0);
    out_q.delete();

    // Round-to-zero, then truncation on the same negative beat
    wr(8'h00, 32'h1);
    push(0, 1'b1, 17'h1FFFF);
    wait_out(1, "rtz_timeout");
    chk_seq("rtz", '{32'h10000});
    wr(8'h00, 32'h0);
    push(0, 1'b1, 17'h1FFFF);
    wait_out(1, "trunc_timeout");
    chk_seq("trunc", '{32'h1FFFF});

    // Ports 0 and 2 with 3-beat packets after reset
    do_reset();
    push(0, 1'b0, 17'h00200); push(0, 1'b0, 17'h00202); push(0, 1'b1, 17'h00204);
    push(2, 1'b0, 17'h00240); push(2, 1'b0, 17'h00242); push(2, 1'b1, 17'h00244);
    wait_out(6, "p02_timeout");
    chk_seq("p02", '{32'h00100, 32'h00101, 32'h10102, 32'h40120, 32'h40121, 32'h50122});

    // Ports 1 and 3 continuously requesting, alternate per packet
    do_reset();
    push(1, 1'b0, 17'h00260); push(1, 1'b1, 17'h00262);
    push(1, 1'b0, 17'h00264); push(1, 1'b1, 17'h00266);
    push(3, 1'b0, 17'h002A0); push(3, 1'b1, 17'h002A2);
    push(3, 1'b0, 17'h002A4); push(3, 1'b1, 17'h002A6);
    wait_out(8, "p13_timeout");
    chk_seq("p13", '{32'h20130, 32'h30131, 32'h60150, 32'h70151,
                     32'h20132, 32'h30133, 32'h60152, 32'h70153});

    // Output backpressure for 5 cycles mid-packet
    push(0, 1'b0, 17'h00400); push(0, 1'b0, 17'h00402);
    push(0, 1'b0, 17'h00404); push(0, 1'b1, 17'h00406);
    wait_out(1, "bp_start_timeout");
    tick();
    o_tready = 1'b0;
    @(negedge clk);
    held = o_tdata;
    chk("bp_valid", 32'(o_tvalid), 32'h1);
    chk("bp_ready_low", 32'(i_tready), 32'h0);
    repeat (5) tick();
    @(negedge clk);
    chk("bp_stable", 32'(o_tdata), 32'(held));
    chk("bp_ready_still_low", 32'(i_tready), 32'h0);
    tick();
    o_tready = 1'b1;
    wait_out(4, "bp_timeout");
    repeat (5) tick();
    chk("bp_count", 32'(out_q.size()), 32'd4);
    chk_seq("bp", '{32'h00200, 32'h00201, 32'h00202, 32'h10203});

    // Mode write to the granted port mid-packet affects next packet only
    o_tready = 1'b0;
    push(0, 1'b0, 17'h00003); push(0, 1'b0, 17'h00003); push(0, 1'b1, 17'h00003);
    repeat (4) tick();
    chk("mw_busy", 32'(busy), 32'h1);
    wr(8'h00, 32'h0);
    o_tready = 1'b1;
    wait_out(3, "mw_timeout");
    chk_seq("mw_old", '{32'h00002, 32'h00002, 32'h10002});
    push(0, 1'b1, 17'h00003);
    wait_out(1, "mw_new_timeout");
    chk_seq("mw_new", '{32'h10001});

    // Reset in the middle of a stalled packet
    o_tready = 1'b0;
    push(1, 1'b0, 17'h00600); push(1, 1'b0, 17'h00602);
    push(1, 1'b0, 17'h00604); push(1, 1'b1, 17'h00606);
    repeat (4) tick();
    chk("mr_busy", 32'(busy), 32'h1);
    chk("mr_valid", 32'(o_tvalid), 32'h1);
    reset = 1'b1;
    src_q[1].delete();
    out_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mr_o_tvalid", 32'(o_tvalid), 32'h0);
    chk("mr_o_tdata",  32'(o_tdata),  32'h0);
    chk("mr_o_tlast",  32'(o_tlast),  32'h0);
    chk("mr_o_tuser",  32'(o_tuser),  32'h0);
    chk("mr_busy_clr", 32'(busy),     32'h0);
    chk("mr_i_tready", 32'(i_tready), 32'h0);
    tick();
    reset = 1'b0;
    o_tready = 1'b1;
    repeat (4) tick();
    chk("mr_no_remainder", 32'(out_q.size()), 32'd0);
    chk("mr_idle", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
